// File: rtl/vga_osd_fill_master.sv
// vga_osd_fill_master
// Avalon-MM write master for the VGA OSD controller host port. One command
// either paints a solid, screen-clipped rectangle into the 640x480 pixel RAM
// or loads the six-word hardware-cursor register bank at RAM_SIZE.
//
// Ports:
//   avs_s1_clk_iCLK / avs_s1_reset_n_iRST_N : clock, async active-low reset
//   iSTART, iMODE                            : command strobe, 0=fill 1=cursor
//   iX0, iY0, iW, iH, iFILL_DATA             : rectangle command fields
//   iCUR_EN, iCUR_X..iCUR_B                  : cursor command fields
//   oBUSY, oDONE                             : busy level, 1-cycle done pulse
//   avm_m1_*                                 : Avalon-MM master (write only)
//   oSTATE_DBG                               : current FSM state (debug)
//
// Handshake: iSTART is a single-cycle request that is taken only while the
// FSM is IDLE (oBUSY low); anything else is dropped. On the bus side each
// cycle with avm_m1_write_oWR high is one complete transfer, because the
// slave has no waitrequest. All bus outputs come straight from flops.
module vga_osd_fill_master #(
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter logic [18:0] RAM_SIZE = 19'h4B000
) (
  input  logic        avs_s1_clk_iCLK,
  input  logic        avs_s1_reset_n_iRST_N,
  input  logic        iSTART,
  input  logic        iMODE,
  input  logic [9:0]  iX0,
  input  logic [9:0]  iY0,
  input  logic [9:0]  iW,
  input  logic [9:0]  iH,
  input  logic [15:0] iFILL_DATA,
  input  logic [3:0]  iCUR_EN,
  input  logic [9:0]  iCUR_X,
  input  logic [9:0]  iCUR_Y,
  input  logic [9:0]  iCUR_R,
  input  logic [9:0]  iCUR_G,
  input  logic [9:0]  iCUR_B,
  output logic        oBUSY,
  output logic        oDONE,
  output logic [18:0] avm_m1_address_oADDR,
  output logic [15:0] avm_m1_writedata_oDATA,
  output logic        avm_m1_write_oWR,
  output logic        avm_m1_chipselect_oCS,
  output logic        avm_m1_read_oRD,
  output logic [1:0]  oSTATE_DBG
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_CURSOR = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] col_q, col_d;             // column offset of the write on the bus
  logic [10:0] rows_left_q, rows_left_d; // rows left, counting the current one
  logic [10:0] w_eff_q, w_eff_d;
  logic [9:0]  x0_q, x0_d;
  logic [18:0] row_base_q, row_base_d;
  logic [15:0] fill_q, fill_d;
  logic [2:0]  cur_idx_q, cur_idx_d;
  logic [3:0]  cur_en_q, cur_en_d;
  logic [9:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [9:0]  cur_r_q, cur_r_d, cur_g_q, cur_g_d, cur_b_q, cur_b_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d, busy_q, busy_d, done_q, done_d;

  // Accept-time clipping. 11-bit arithmetic keeps H_RES - x and the
  // comparisons free of overflow.
  logic [10:0] x_ext, y_ext, w_ext, h_ext, x_room, y_room, w_clip, h_clip;
  logic        fill_empty;
  logic [18:0] first_row_base;

  always_comb begin
    x_ext      = {1'b0, iX0};
    y_ext      = {1'b0, iY0};
    w_ext      = {1'b0, iW};
    h_ext      = {1'b0, iH};
    x_room     = 11'(H_RES) - x_ext;
    y_room     = 11'(V_RES) - y_ext;
    w_clip     = (w_ext < x_room) ? w_ext : x_room;
    h_clip     = (h_ext < y_room) ? h_ext : y_room;
    fill_empty = (x_ext >= 11'(H_RES)) || (y_ext >= 11'(V_RES)) ||
                 (iW == 10'd0) || (iH == 10'd0);
    // Constant multiply, only on the accept path; rows then step by H_RES.
    first_row_base = 19'(iY0) * 19'(H_RES);
  end

  function automatic logic [15:0] cursor_word(
    input logic [2:0] idx, input logic [3:0] en,
    input logic [9:0] x, input logic [9:0] y,
    input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    case (idx)
      3'd0:    cursor_word = {12'd0, en};
      3'd1:    cursor_word = {6'd0, x};
      3'd2:    cursor_word = {6'd0, y};
      3'd3:    cursor_word = {6'd0, r};
      3'd4:    cursor_word = {6'd0, g};
      3'd5:    cursor_word = {6'd0, b};
      default: cursor_word = 16'd0;
    endcase
  endfunction

  // The _d values describe the bus cycle that follows the next edge, so the
  // first write is already prepared while the start is being accepted.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    rows_left_d = rows_left_q;
    w_eff_d     = w_eff_q;
    x0_d        = x0_q;
    row_base_d  = row_base_q;
    fill_d      = fill_q;
    cur_idx_d   = cur_idx_q;
    cur_en_d    = cur_en_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    cur_r_d     = cur_r_q;
    cur_g_d     = cur_g_q;
    cur_b_d     = cur_b_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          busy_d = 1'b1;
          if (iMODE) begin
            cur_en_d  = iCUR_EN;
            cur_x_d   = iCUR_X;
            cur_y_d   = iCUR_Y;
            cur_r_d   = iCUR_R;
            cur_g_d   = iCUR_G;
            cur_b_d   = iCUR_B;
            cur_idx_d = 3'd0;
            addr_d    = RAM_SIZE;
            wdata_d   = cursor_word(3'd0, iCUR_EN, iCUR_X, iCUR_Y,
                                    iCUR_R, iCUR_G, iCUR_B);
            wr_d      = 1'b1;
            state_d   = S_CURSOR;
          end else if (fill_empty) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            x0_d        = iX0;
            w_eff_d     = w_clip;
            rows_left_d = h_clip;
            fill_d      = iFILL_DATA;
            row_base_d  = first_row_base;
            col_d       = 11'd0;
            addr_d      = first_row_base + 19'(iX0);
            wdata_d     = iFILL_DATA;
            wr_d        = 1'b1;
            state_d     = S_FILL;
          end
        end
      end

      S_FILL: begin
        busy_d = 1'b1;
        if (col_q == w_eff_q - 11'd1) begin
          if (rows_left_q == 11'd1) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            col_d       = 11'd0;
            rows_left_d = rows_left_q - 11'd1;
            row_base_d  = row_base_q + 19'(H_RES);
            addr_d      = row_base_d + 19'(x0_q);
            wdata_d     = fill_q;
            wr_d        = 1'b1;
          end
        end else begin
          col_d   = col_q + 11'd1;
          addr_d  = row_base_q + 19'(x0_q) + 19'(col_d);
          wdata_d = fill_q;
          wr_d    = 1'b1;
        end
      end

      S_CURSOR: begin
        busy_d = 1'b1;
        if (cur_idx_q == 3'd5) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cur_idx_d = cur_idx_q + 3'd1;
          addr_d    = RAM_SIZE + 19'(cur_idx_d);
          wdata_d   = cursor_word(cur_idx_d, cur_en_q, cur_x_q, cur_y_q,
                                  cur_r_q, cur_g_q, cur_b_q);
          wr_d      = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge avs_s1_clk_iCLK or negedge avs_s1_reset_n_iRST_N) begin
    if (!avs_s1_reset_n_iRST_N) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      rows_left_q <= '0;
      w_eff_q     <= '0;
      x0_q        <= '0;
      row_base_q  <= '0;
      fill_q      <= '0;
      cur_idx_q   <= '0;
      cur_en_q    <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      cur_r_q     <= '0;
      cur_g_q     <= '0;
      cur_b_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      rows_left_q <= rows_left_d;
      w_eff_q     <= w_eff_d;
      x0_q        <= x0_d;
      row_base_q  <= row_base_d;
      fill_q      <= fill_d;
      cur_idx_q   <= cur_idx_d;
      cur_en_q    <= cur_en_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      cur_r_q     <= cur_r_d;
      cur_g_q     <= cur_g_d;
      cur_b_q     <= cur_b_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign avm_m1_address_oADDR   = addr_q;
  assign avm_m1_writedata_oDATA = wdata_q;
  assign avm_m1_write_oWR       = wr_q;
  assign avm_m1_chipselect_oCS  = wr_q;
  assign avm_m1_read_oRD        = 1'b0;
  assign oBUSY                  = busy_q;
  assign oDONE                  = done_q;
  assign oSTATE_DBG             = state_q;

endmodule

// File: doc/vga_osd_fill_master.md
# vga_osd_fill_master

Avalon-MM master that drives the host-side write port of the VGA OSD controller: it paints solid rectangles into the 640x480 OSD pixel RAM and loads the hardware-cursor register bank. It sits between a CPU-facing command interface and the controller's `avs_s1` slave, which it drives directly. Software issues one command and gets a single completion pulse instead of running hundreds of thousands of individual bus writes.

## Interface
- `H_RES`, 640, pixels per row; the row stride of the OSD RAM address.
- `V_RES`, 480, rows.
- `RAM_SIZE`, 19'h4B000, first register address above pixel RAM; the cursor bank starts here.
- `avs_s1_clk_iCLK`  in  1  host clock; all logic on rising edge.
- `avs_s1_reset_n_iRST_N`  in  1  asynchronous active-low reset.
- `iSTART`  in  1  one-cycle command strobe; sampled only in IDLE.
- `iMODE`  in  1  0 = rectangle fill, 1 = cursor load.
- `iX0`, `iY0`  in  10 each  rectangle origin.
- `iW`, `iH`  in  10 each  rectangle width and height in pixels.
- `iFILL_DATA`  in  16  pixel value written to every pixel of the rectangle.
- `iCUR_EN`  in  4  cursor RGB enable.
- `iCUR_X`, `iCUR_Y`, `iCUR_R`, `iCUR_G`, `iCUR_B`  in  10 each  cursor fields.
- `oBUSY`  out  1  high while a command is in progress, including the DONE cycle.
- `oDONE`  out  1  one-cycle completion pulse.
- `avm_m1_address_oADDR`  out  19  slave word address.
- `avm_m1_writedata_oDATA`  out  16  write data.
- `avm_m1_write_oWR`  out  1  write strobe.
- `avm_m1_chipselect_oCS`  out  1  chipselect; equal to `avm_m1_write_oWR`.
- `avm_m1_read_oRD`  out  1  tied 0; this block never reads.

## Operation
- States: IDLE, FILL, CURSOR, DONE.
- IDLE -> FILL when `iSTART`=1 and `iMODE`=0 and the clipped rectangle is non-empty.
- IDLE -> CURSOR when `iSTART`=1 and `iMODE`=1.
- IDLE -> DONE when `iSTART`=1 and `iMODE`=0 and the clipped rectangle is empty.
- FILL -> DONE after the last pixel write.
- CURSOR -> DONE after the 6th write.
- DONE -> IDLE unconditionally after one cycle.
- All command inputs are latched on the accepted start. Later changes to them do not affect the running command.
- Clipping, done at accept time:
  - Empty if `iX0`>=`H_RES`, `iY0`>=`V_RES`, `iW`==0 or `iH`==0.
  - Effective width = min(`iW`, `H_RES`-`iX0`).
  - Effective height = min(`iH`, `V_RES`-`iY0`).
  - Intermediate sums are 11 bits wide so they cannot overflow.
- FILL order: raster order, left to right, then top to bottom. One write per clock, no gaps.
- Address = row_base + x, where row_base starts at `iY0`*`H_RES`.
- row_base advances by adding `H_RES` at end of each row. It is 19 bits and is computed incrementally, with no multiplier in the pixel loop.
- The first row_base is computed at accept time. A shift/add form is acceptable for 640 (y<<9 + y<<7).
- Every fill address is < `RAM_SIZE` by construction.
- CURSOR: six consecutive writes to `RAM_SIZE`+0..5 carrying `iCUR_EN` (zero-extended), X, Y, R, G, B (each zero-extended to 16 bits).
- `iSTART` while busy is ignored: no queueing, no error.
- Reset, including mid-command: state goes to IDLE and all outputs deassert immediately. A partially painted rectangle is left as-is.

## Timing
- Reset values: `avm_m1_address_oADDR`=0, `avm_m1_writedata_oDATA`=0, write/chipselect/read=0, `oBUSY`=0, `oDONE`=0.
- All master outputs are registered on the rising edge, so they are stable at the following falling edge, where the slave samples.
- The slave has no waitrequest. Each asserted write cycle is exactly one completed transfer.
- Start accepted at edge 0:
  - First write is valid in cycle 1.
  - For N writes, writes occupy cycles 1..N.
  - `oDONE`=1 and `avm_m1_write_oWR`=0 in cycle N+1.
  - `oBUSY` is high in cycles 1..N+1.
  - The next start is accepted no earlier than edge N+2.
- Empty fill: `oDONE` in cycle 1, no writes.
- Cursor load: N=6, so `oDONE` in cycle 7.

## Test plan
- Fill (x0=10, y0=5, w=3, h=2, data 16'hFFFF) -> writes in cycles 1..6 at 3210, 3211, 3212, 3850, 3851, 3852, all data FFFF; `oDONE` in cycle 7, exactly one pulse.
- Clip (x0=638, y0=479, w=5, h=3) -> exactly 2 writes at 307198 and 307199 (19'h4AFFF); no address >= 19'h4B000; `oDONE` in cycle 3.
- Empty commands (w=0; then separately x0=640) -> zero writes; `oDONE` in cycle 1 each.
- Cursor load (EN=4'hF, X=100, Y=200, R=1023, G=0, B=512) -> writes at 19'h4B000..19'h4B005 with data 000F, 0064, 00C8, 03FF, 0000, 0200; `oDONE` in cycle 7.
- Start re-pulsed mid-fill with different inputs -> ignored; the original rectangle completes unchanged; a new start is accepted only after `oDONE`.
- Reset asserted mid-fill at write 4 of 6 -> write and busy drop immediately with no further writes; after release, a new fill starts cleanly from its own origin.
